// File: rtl/pipe_regs_dam_if.sv
// Bus bundle for the D/A/M pipeline register block: stage inputs, stage outputs
// and the externally computed ALU result that feeds the M stage.
interface pipe_regs_dam_if #(
    parameter int INSTR_WIDTH  = 32,
    parameter int PC_WIDTH     = 5,
    parameter int REG_WIDTH    = 32,
    parameter int REG_SELECT   = 5,
    parameter int ALU_OP_WIDTH = 4
);
    logic [INSTR_WIDTH-1:0]  d_i_instruction;
    logic [PC_WIDTH-1:0]     d_i_pc;
    logic [INSTR_WIDTH-1:0]  d_o_instruction;
    logic [PC_WIDTH-1:0]     d_o_pc;

    logic [REG_WIDTH-1:0]    a_i_reg_a;
    logic [REG_WIDTH-1:0]    a_i_reg_b;
    logic [REG_WIDTH-1:0]    a_i_offset;
    logic [REG_SELECT-1:0]   a_i_reg_a_select;
    logic [REG_SELECT-1:0]   a_i_reg_b_select;
    logic [REG_SELECT-1:0]   a_i_reg_c_select;
    logic                    a_i_is_write;
    logic                    a_i_is_load;
    logic                    a_i_is_store;
    logic [ALU_OP_WIDTH-1:0] a_i_alu_op;

    logic [REG_WIDTH-1:0]    a_o_reg_a;
    logic [REG_WIDTH-1:0]    a_o_reg_b;
    logic [REG_WIDTH-1:0]    a_o_offset;
    logic [REG_SELECT-1:0]   a_o_reg_a_select;
    logic [REG_SELECT-1:0]   a_o_reg_b_select;
    logic [REG_SELECT-1:0]   a_o_reg_c_select;
    logic                    a_o_is_write;
    logic                    a_o_is_load;
    logic                    a_o_is_store;
    logic [ALU_OP_WIDTH-1:0] a_o_alu_op;

    logic [REG_WIDTH-1:0]    m_i_alu_data;
    logic [REG_WIDTH-1:0]    m_o_reg_b;
    logic [REG_WIDTH-1:0]    m_o_alu_data;
    logic [REG_SELECT-1:0]   m_o_reg_c_select;
    logic                    m_o_is_write;
    logic                    m_o_is_load;
    logic                    m_o_is_store;

    modport slave (
        input  d_i_instruction, d_i_pc,
        input  a_i_reg_a, a_i_reg_b, a_i_offset,
        input  a_i_reg_a_select, a_i_reg_b_select, a_i_reg_c_select,
        input  a_i_is_write, a_i_is_load, a_i_is_store, a_i_alu_op,
        input  m_i_alu_data,
        output d_o_instruction, d_o_pc,
        output a_o_reg_a, a_o_reg_b, a_o_offset,
        output a_o_reg_a_select, a_o_reg_b_select, a_o_reg_c_select,
        output a_o_is_write, a_o_is_load, a_o_is_store, a_o_alu_op,
        output m_o_reg_b, m_o_alu_data, m_o_reg_c_select,
        output m_o_is_write, m_o_is_load, m_o_is_store
    );

    modport master (
        output d_i_instruction, d_i_pc,
        output a_i_reg_a, a_i_reg_b, a_i_offset,
        output a_i_reg_a_select, a_i_reg_b_select, a_i_reg_c_select,
        output a_i_is_write, a_i_is_load, a_i_is_store, a_i_alu_op,
        output m_i_alu_data,
        input  d_o_instruction, d_o_pc,
        input  a_o_reg_a, a_o_reg_b, a_o_offset,
        input  a_o_reg_a_select, a_o_reg_b_select, a_o_reg_c_select,
        input  a_o_is_write, a_o_is_load, a_o_is_store, a_o_alu_op,
        input  m_o_reg_b, m_o_alu_data, m_o_reg_c_select,
        input  m_o_is_write, m_o_is_load, m_o_is_store
    );
endinterface

// File: rtl/pipe_regs_dam.sv
// Three in-order pipeline register stages (D, A, M) sharing one stall enable;
// D can additionally be squashed to a bubble by flush.
module pipe_regs_dam #(
    parameter int INSTR_WIDTH  = 32,
    parameter int PC_WIDTH     = 5,
    parameter int REG_WIDTH    = 32,
    parameter int REG_SELECT   = 5,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               flush,
    pipe_regs_dam_if.slave     bus
);

    logic [INSTR_WIDTH-1:0]  d_instruction_r, d_instruction_s;
    logic [PC_WIDTH-1:0]     d_pc_r, d_pc_s;

    logic [REG_WIDTH-1:0]    a_reg_a_r, a_reg_a_s;
    logic [REG_WIDTH-1:0]    a_reg_b_r, a_reg_b_s;
    logic [REG_WIDTH-1:0]    a_offset_r, a_offset_s;
    logic [REG_SELECT-1:0]   a_reg_a_select_r, a_reg_a_select_s;
    logic [REG_SELECT-1:0]   a_reg_b_select_r, a_reg_b_select_s;
    logic [REG_SELECT-1:0]   a_reg_c_select_r, a_reg_c_select_s;
    logic                    a_is_write_r, a_is_write_s;
    logic                    a_is_load_r, a_is_load_s;
    logic                    a_is_store_r, a_is_store_s;
    logic [ALU_OP_WIDTH-1:0] a_alu_op_r, a_alu_op_s;

    logic [REG_WIDTH-1:0]    m_reg_b_r, m_reg_b_s;
    logic [REG_WIDTH-1:0]    m_alu_data_r, m_alu_data_s;
    logic [REG_SELECT-1:0]   m_reg_c_select_r, m_reg_c_select_s;
    logic                    m_is_write_r, m_is_write_s;
    logic                    m_is_load_r, m_is_load_s;
    logic                    m_is_store_r, m_is_store_s;

    // D stage next value: flush squashes to a bubble even while stalled
    always_comb begin
        d_instruction_s = d_instruction_r;
        d_pc_s          = d_pc_r;
        if (flush) begin
            d_instruction_s = '0;
            d_pc_s          = '0;
        end else if (enable) begin
            d_instruction_s = bus.d_i_instruction;
            d_pc_s          = bus.d_i_pc;
        end else begin
            d_instruction_s = d_instruction_r;
            d_pc_s          = d_pc_r;
        end
    end

    // A stage next value: plain capture-or-hold
    always_comb begin
        a_reg_a_s        = a_reg_a_r;
        a_reg_b_s        = a_reg_b_r;
        a_offset_s       = a_offset_r;
        a_reg_a_select_s = a_reg_a_select_r;
        a_reg_b_select_s = a_reg_b_select_r;
        a_reg_c_select_s = a_reg_c_select_r;
        a_is_write_s     = a_is_write_r;
        a_is_load_s      = a_is_load_r;
        a_is_store_s     = a_is_store_r;
        a_alu_op_s       = a_alu_op_r;
        if (enable) begin
            a_reg_a_s        = bus.a_i_reg_a;
            a_reg_b_s        = bus.a_i_reg_b;
            a_offset_s       = bus.a_i_offset;
            a_reg_a_select_s = bus.a_i_reg_a_select;
            a_reg_b_select_s = bus.a_i_reg_b_select;
            a_reg_c_select_s = bus.a_i_reg_c_select;
            a_is_write_s     = bus.a_i_is_write;
            a_is_load_s      = bus.a_i_is_load;
            a_is_store_s     = bus.a_i_is_store;
            a_alu_op_s       = bus.a_i_alu_op;
        end else begin
            a_alu_op_s       = a_alu_op_r;
        end
    end

    // M stage next value: fed from the current A registers, not the A inputs
    always_comb begin
        m_reg_b_s        = m_reg_b_r;
        m_alu_data_s     = m_alu_data_r;
        m_reg_c_select_s = m_reg_c_select_r;
        m_is_write_s     = m_is_write_r;
        m_is_load_s      = m_is_load_r;
        m_is_store_s     = m_is_store_r;
        if (enable) begin
            m_reg_b_s        = a_reg_b_r;
            m_alu_data_s     = bus.m_i_alu_data;
            m_reg_c_select_s = a_reg_c_select_r;
            m_is_write_s     = a_is_write_r;
            m_is_load_s      = a_is_load_r;
            m_is_store_s     = a_is_store_r;
        end else begin
            m_alu_data_s     = m_alu_data_r;
        end
    end

    // Stage registers with synchronous reset overriding flush and enable
    always_ff @(posedge clk) begin
        if (rst) begin
            d_instruction_r  <= '0;
            d_pc_r           <= '0;
            a_reg_a_r        <= '0;
            a_reg_b_r        <= '0;
            a_offset_r       <= '0;
            a_reg_a_select_r <= '0;
            a_reg_b_select_r <= '0;
            a_reg_c_select_r <= '0;
            a_is_write_r     <= 1'b0;
            a_is_load_r      <= 1'b0;
            a_is_store_r     <= 1'b0;
            a_alu_op_r       <= '0;
            m_reg_b_r        <= '0;
            m_alu_data_r     <= '0;
            m_reg_c_select_r <= '0;
            m_is_write_r     <= 1'b0;
            m_is_load_r      <= 1'b0;
            m_is_store_r     <= 1'b0;
        end else begin
            d_instruction_r  <= d_instruction_s;
            d_pc_r           <= d_pc_s;
            a_reg_a_r        <= a_reg_a_s;
            a_reg_b_r        <= a_reg_b_s;
            a_offset_r       <= a_offset_s;
            a_reg_a_select_r <= a_reg_a_select_s;
            a_reg_b_select_r <= a_reg_b_select_s;
            a_reg_c_select_r <= a_reg_c_select_s;
            a_is_write_r     <= a_is_write_s;
            a_is_load_r      <= a_is_load_s;
            a_is_store_r     <= a_is_store_s;
            a_alu_op_r       <= a_alu_op_s;
            m_reg_b_r        <= m_reg_b_s;
            m_alu_data_r     <= m_alu_data_s;
            m_reg_c_select_r <= m_reg_c_select_s;
            m_is_write_r     <= m_is_write_s;
            m_is_load_r      <= m_is_load_s;
            m_is_store_r     <= m_is_store_s;
        end
    end

    assign bus.d_o_instruction  = d_instruction_r;
    assign bus.d_o_pc           = d_pc_r;
    assign bus.a_o_reg_a        = a_reg_a_r;
    assign bus.a_o_reg_b        = a_reg_b_r;
    assign bus.a_o_offset       = a_offset_r;
    assign bus.a_o_reg_a_select = a_reg_a_select_r;
    assign bus.a_o_reg_b_select = a_reg_b_select_r;
    assign bus.a_o_reg_c_select = a_reg_c_select_r;
    assign bus.a_o_is_write     = a_is_write_r;
    assign bus.a_o_is_load      = a_is_load_r;
    assign bus.a_o_is_store     = a_is_store_r;
    assign bus.a_o_alu_op       = a_alu_op_r;
    assign bus.m_o_reg_b        = m_reg_b_r;
    assign bus.m_o_alu_data     = m_alu_data_r;
    assign bus.m_o_reg_c_select = m_reg_c_select_r;
    assign bus.m_o_is_write     = m_is_write_r;
    assign bus.m_o_is_load      = m_is_load_r;
    assign bus.m_o_is_store     = m_is_store_r;

endmodule

// File: tb/tb_pipe_regs_dam.sv
// Scoreboard bench for pipe_regs_dam: directed steps push hand-composed expected
// stage contents; a monitor compares them one cycle-edge later.
module tb_pipe_regs_dam;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  pc;
    } d_t;

    typedef struct packed {
        logic [31:0] reg_a;
        logic [31:0] reg_b;
        logic [31:0] offset;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  sc;
        logic        w;
        logic        l;
        logic        s;
        logic [3:0]  op;
    } a_t;

    typedef struct packed {
        logic [31:0] reg_b;
        logic [31:0] alu;
        logic [4:0]  sc;
        logic        w;
        logic        l;
        logic        s;
    } m_t;

    typedef struct packed {
        d_t          d;
        a_t          a;
        logic [31:0] alu;
    } vec_t;

    typedef struct packed {
        d_t d;
        a_t a;
        m_t m;
    } exp_t;

    logic clk;
    logic rst;
    logic enable;
    logic flush;

    pipe_regs_dam_if #(.INSTR_WIDTH(32), .PC_WIDTH(5), .REG_WIDTH(32),
                       .REG_SELECT(5), .ALU_OP_WIDTH(4)) bus ();

    pipe_regs_dam #(.INSTR_WIDTH(32), .PC_WIDTH(5), .REG_WIDTH(32),
                    .REG_SELECT(5), .ALU_OP_WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .flush  (flush),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    vec_t v0, v1, v2, v3;
    d_t   dz;
    a_t   az;
    exp_t ez;

    function automatic m_t m_from(input a_t a, input logic [31:0] alu);
        m_t r;
        r.reg_b = a.reg_b;
        r.alu   = alu;
        r.sc    = a.sc;
        r.w     = a.w;
        r.l     = a.l;
        r.s     = a.s;
        return r;
    endfunction

    function automatic exp_t mk(input d_t d, input a_t a, input m_t m);
        exp_t r;
        r.d = d;
        r.a = a;
        r.m = m;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic step(input vec_t v, input logic r, input logic e, input logic f, input exp_t x);
        @(negedge clk);
        bus.d_i_instruction  = v.d.instr;
        bus.d_i_pc           = v.d.pc;
        bus.a_i_reg_a        = v.a.reg_a;
        bus.a_i_reg_b        = v.a.reg_b;
        bus.a_i_offset       = v.a.offset;
        bus.a_i_reg_a_select = v.a.sa;
        bus.a_i_reg_b_select = v.a.sb;
        bus.a_i_reg_c_select = v.a.sc;
        bus.a_i_is_write     = v.a.w;
        bus.a_i_is_load      = v.a.l;
        bus.a_i_is_store     = v.a.s;
        bus.a_i_alu_op       = v.a.op;
        bus.m_i_alu_data     = v.alu;
        rst    = r;
        enable = e;
        flush  = f;
        exp_q.push_back(x);
    endtask

    // Monitor: one expected snapshot per active edge, sampled just after it
    initial begin
        exp_t e;
        d_t   ad;
        a_t   aa;
        m_t   am;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ad = '{instr: bus.d_o_instruction, pc: bus.d_o_pc};
                aa = '{reg_a: bus.a_o_reg_a, reg_b: bus.a_o_reg_b, offset: bus.a_o_offset,
                       sa: bus.a_o_reg_a_select, sb: bus.a_o_reg_b_select,
                       sc: bus.a_o_reg_c_select, w: bus.a_o_is_write,
                       l: bus.a_o_is_load, s: bus.a_o_is_store, op: bus.a_o_alu_op};
                am = '{reg_b: bus.m_o_reg_b, alu: bus.m_o_alu_data,
                       sc: bus.m_o_reg_c_select, w: bus.m_o_is_write,
                       l: bus.m_o_is_load, s: bus.m_o_is_store};
                check("d_stage", 128'(ad), 128'(e.d));
                check("a_stage", 128'(aa), 128'(e.a));
                check("m_stage", 128'(am), 128'(e.m));
            end
        end
    end

    initial begin
        v0.d = '{instr: 32'hDEADBEEF, pc: 5'h05};
        v0.a = '{reg_a: 32'h1111_1111, reg_b: 32'h0000_1234, offset: 32'h0000_0010,
                 sa: 5'd1, sb: 5'd2, sc: 5'd7, w: 1'b1, l: 1'b0, s: 1'b1, op: 4'h3};
        v0.alu = 32'hA5A5A5A5;
        v1.d = '{instr: 32'h00500093, pc: 5'h0C};
        v1.a = '{reg_a: 32'hAAAA_0001, reg_b: 32'h0000_5678, offset: 32'hFFFF_FFFC,
                 sa: 5'd3, sb: 5'd4, sc: 5'd9, w: 1'b0, l: 1'b1, s: 1'b0, op: 4'hF};
        v1.alu = 32'h0F0F0F0F;
        v2.d = '{instr: 32'h12345678, pc: 5'h1F};
        v2.a = '{reg_a: 32'h0000_0000, reg_b: 32'hFFFF_FFFF, offset: 32'h8000_0000,
                 sa: 5'd31, sb: 5'd0, sc: 5'd31, w: 1'b1, l: 1'b1, s: 1'b1, op: 4'h8};
        v2.alu = 32'h80000001;
        v3.d = '{instr: 32'hCAFEF00D, pc: 5'h11};
        v3.a = '{reg_a: 32'h7654_3210, reg_b: 32'h0BAD_F00D, offset: 32'h0000_0004,
                 sa: 5'd10, sb: 5'd20, sc: 5'd30, w: 1'b0, l: 1'b0, s: 1'b1, op: 4'h5};
        v3.alu = 32'h5A5A5A5A;
        dz = '0;
        az = '0;
        ez = '0;

        rst = 1'b1;
        enable = 1'b0;
        flush = 1'b0;

        // reset with nonzero inputs, then release
        step(v0, 1'b1, 1'b1, 1'b0, ez);
        step(v0, 1'b0, 1'b1, 1'b0, mk(v0.d, v0.a, m_from(az, v0.alu)));
        // second capture: M gets A's first contents (reg_b 0x1234, sc 7, store)
        step(v1, 1'b0, 1'b1, 1'b0, mk(v1.d, v1.a, m_from(v0.a, v1.alu)));
        // three-edge stall with changing inputs
        step(v2, 1'b0, 1'b0, 1'b0, mk(v1.d, v1.a, m_from(v0.a, v1.alu)));
        step(v3, 1'b0, 1'b0, 1'b0, mk(v1.d, v1.a, m_from(v0.a, v1.alu)));
        step(v0, 1'b0, 1'b0, 1'b0, mk(v1.d, v1.a, m_from(v0.a, v1.alu)));
        step(v2, 1'b0, 1'b1, 1'b0, mk(v2.d, v2.a, m_from(v1.a, v2.alu)));
        // flush with enable: D bubble, A/M capture
        step(v1, 1'b0, 1'b1, 1'b1, mk(dz, v1.a, m_from(v2.a, v1.alu)));
        step(v3, 1'b0, 1'b1, 1'b0, mk(v3.d, v3.a, m_from(v1.a, v3.alu)));
        // flush during stall: D bubble, A/M hold
        step(v0, 1'b0, 1'b0, 1'b1, mk(dz, v3.a, m_from(v1.a, v3.alu)));
        step(v2, 1'b0, 1'b0, 1'b0, mk(dz, v3.a, m_from(v1.a, v3.alu)));
        step(v0, 1'b0, 1'b1, 1'b0, mk(v0.d, v0.a, m_from(v3.a, v0.alu)));
        // reset wins over flush and stall
        step(v1, 1'b1, 1'b0, 1'b1, ez);
        step(v2, 1'b0, 1'b0, 1'b0, ez);
        step(v2, 1'b0, 1'b1, 1'b0, mk(v2.d, v2.a, m_from(az, v2.alu)));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
